// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the load/store data memory controller.
package data_mem_pkg;

  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_RSV} mem_size_e;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_e;

  // Byte lanes touched by an access; reserved size touches nothing.
  function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] addr_lo);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      MEM_B:   be = 4'b0001 << addr_lo;
      MEM_H:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
      MEM_W:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/data_mem_lane.sv
// Combinational lane logic: store replication, byte enables, load select/extend
// and misalignment detection.
module data_mem_lane
  import data_mem_pkg::*;
(
  input  mem_size_e   size,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign be       = byte_en(size, addr_lo);
  assign byte_sel = rword[{addr_lo, 3'b000} +: 8];
  assign half_sel = rword[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    wdata_rep  = wdata;
    rdata_ext  = rword;
    misaligned = 1'b0;
    case (size)
      MEM_B: begin
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      MEM_H: begin
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misaligned = addr_lo[0];
      end
      MEM_W: begin
        misaligned = (addr_lo != 2'b00);
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory with byte/half/word access, configurable latency and a
// valid/ready request handshake; one outstanding request at a time.
module data_mem_ctrl
  import data_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         IDX_W  = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LAT_M1 = 3'(LATENCY - 1);

  typedef logic [31:0] mem_t [DEPTH_WORDS];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH_WORDS; i++) m[i] = 32'(i);
    return m;
  endfunction

  mem_t mem = init_mem();

  state_e      state;
  logic [2:0]  cnt;
  logic        lat_we, lat_unsigned;
  mem_size_e   lat_size;
  logic [31:0] lat_addr, lat_wdata;

  logic        cur_we, cur_unsigned;
  mem_size_e   cur_size;
  logic [31:0] cur_addr, cur_wdata;

  logic             accept, commit, out_of_range, misaligned, err;
  logic [IDX_W-1:0] idx;
  logic [3:0]       be;
  logic [31:0]      wdata_rep, rdata_ext, rword;

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign accept    = (state == ST_IDLE) && req_valid;

  // With LATENCY=1 the commit edge is the acceptance edge, so the live inputs
  // drive the access; otherwise the latched copy does.
  always_comb begin
    cur_we       = lat_we;
    cur_size     = lat_size;
    cur_unsigned = lat_unsigned;
    cur_addr     = lat_addr;
    cur_wdata    = lat_wdata;
    if (state == ST_IDLE) begin
      cur_we       = req_we;
      cur_size     = mem_size_e'(req_size);
      cur_unsigned = req_unsigned;
      cur_addr     = req_addr;
      cur_wdata    = req_wdata;
    end
  end

  assign commit       = (accept && (LATENCY == 1)) || ((state == ST_WAIT) && (cnt == 3'd1));
  assign out_of_range = |cur_addr[31:IDX_W+2];
  assign idx          = cur_addr[IDX_W+1:2];
  assign rword        = mem[idx];
  assign err          = out_of_range || misaligned;

  data_mem_lane u_lane (
    .size        (cur_size),
    .addr_lo     (cur_addr[1:0]),
    .is_unsigned (cur_unsigned),
    .wdata       (cur_wdata),
    .rword       (rword),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata_ext   (rdata_ext),
    .misaligned  (misaligned)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cnt          <= 3'd0;
      lat_we       <= 1'b0;
      lat_size     <= MEM_B;
      lat_unsigned <= 1'b0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we       <= req_we;
            lat_size     <= mem_size_e'(req_size);
            lat_unsigned <= req_unsigned;
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            cnt          <= LAT_M1;
            state        <= (LAT_M1 == 3'd0) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) state <= ST_RESP;
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= err;
      rsp_rdata <= (err || cur_we) ? 32'h0 : rdata_ext;
    end
  end

  // The array itself is never reset; faulting requests write nothing.
  always_ff @(posedge clk) begin
    if (commit && cur_we && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with instances at LATENCY 1, 3 and 4.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        valid1, valid3, valid4;
  logic        ready1, ready3, ready4;
  logic        rsp_valid1, rsp_valid3, rsp_valid4;
  logic [31:0] rsp_rdata1, rsp_rdata3, rsp_rdata4;
  logic        rsp_err1, rsp_err3, rsp_err4;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid1), .req_ready(ready1), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid3), .req_ready(ready3), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
  );

  data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(4)) u_lat4 (
    .clk(clk), .rst_n(rst_n), .req_valid(valid4), .req_ready(ready4), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic driveReq(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // One LATENCY=1 transaction: accept, check the response cycle, then check hold.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    driveReq(v.we, v.size, v.uns, v.addr, v.wdata);
    valid1 = 1'b1;
    @(posedge clk);
    #1;
    valid1 = 1'b0;
    checkOutput({v.name, " rsp_valid"}, 32'(rsp_valid1), 32'd1);
    checkOutput({v.name, " req_ready"}, 32'(ready1), 32'd0);
    checkOutput({v.name, " rdata"}, rsp_rdata1, v.exp_rdata);
    checkOutput({v.name, " err"}, 32'(rsp_err1), 32'(v.exp_err));
    @(posedge clk);
    #1;
    checkOutput({v.name, " rsp_valid drop"}, 32'(rsp_valid1), 32'd0);
    checkOutput({v.name, " rdata hold"}, rsp_rdata1, v.exp_rdata);
  endtask

  // LATENCY=3 transaction with exact response timing.
  task automatic runLat3(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
    @(negedge clk);
    driveReq(we, 2'b10, 1'b0, addr, wdata);
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      checkOutput($sformatf("%s rsp_valid c%0d", name, k + 1), 32'(rsp_valid3), (k == 2) ? 32'd1 : 32'd0);
    end
    checkOutput({name, " rdata"}, rsp_rdata3, exp_rdata);
    checkOutput({name, " err"}, 32'(rsp_err3), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    valid1 = 1'b0;
    valid3 = 1'b0;
    valid4 = 1'b0;
    driveReq(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);

    vecs.push_back('{"ld w 0x10",        1'b0, 2'b10, 1'b0, 32'h010, 32'h0,        32'h0000_0004, 1'b0});
    vecs.push_back('{"st b 0x21",        1'b1, 2'b00, 1'b0, 32'h021, 32'h0000_00AB, 32'h0,         1'b0});
    vecs.push_back('{"ld w 0x20",        1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        32'h0000_AB08, 1'b0});
    vecs.push_back('{"ld b s 0x21",      1'b0, 2'b00, 1'b0, 32'h021, 32'h0,        32'hFFFF_FFAB, 1'b0});
    vecs.push_back('{"ld b u 0x21",      1'b0, 2'b00, 1'b1, 32'h021, 32'h0,        32'h0000_00AB, 1'b0});
    vecs.push_back('{"st h 0x42",        1'b1, 2'b01, 1'b0, 32'h042, 32'h0000_8001, 32'h0,         1'b0});
    vecs.push_back('{"ld w 0x40",        1'b0, 2'b10, 1'b1, 32'h040, 32'h0,        32'h8001_0010, 1'b0});
    vecs.push_back('{"ld h s 0x42",      1'b0, 2'b01, 1'b0, 32'h042, 32'h0,        32'hFFFF_8001, 1'b0});
    vecs.push_back('{"ld h u 0x42",      1'b0, 2'b01, 1'b1, 32'h042, 32'h0,        32'h0000_8001, 1'b0});
    vecs.push_back('{"ld b s 0x43",      1'b0, 2'b00, 1'b0, 32'h043, 32'h0,        32'hFFFF_FF80, 1'b0});
    vecs.push_back('{"ld w 0x22 misal",  1'b0, 2'b10, 1'b0, 32'h022, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{"st w 0x23 misal",  1'b1, 2'b10, 1'b0, 32'h023, 32'h1234_5678, 32'h0,         1'b1});
    vecs.push_back('{"st h 0x21 misal",  1'b1, 2'b01, 1'b0, 32'h021, 32'h0000_5555, 32'h0,         1'b1});
    vecs.push_back('{"ld w 0x400 range", 1'b0, 2'b10, 1'b0, 32'h400, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{"st b 0x400 range", 1'b1, 2'b00, 1'b0, 32'h400, 32'h0000_0077, 32'h0,         1'b1});
    vecs.push_back('{"ld rsv 0x20",      1'b0, 2'b11, 1'b0, 32'h020, 32'h0,        32'h0,         1'b1});
    vecs.push_back('{"ld w 0x20 intact", 1'b0, 2'b10, 1'b0, 32'h020, 32'h0,        32'h0000_AB08, 1'b0});
    vecs.push_back('{"st b 0x3FF",       1'b1, 2'b00, 1'b0, 32'h3FF, 32'h1234_567F, 32'h0,         1'b0});
    vecs.push_back('{"ld w 0x3FC",       1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,        32'h7F00_00FF, 1'b0});
    vecs.push_back('{"ld w 0x0 intact",  1'b0, 2'b10, 1'b0, 32'h000, 32'h0,        32'h0000_0000, 1'b0});

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset rsp_valid", 32'(rsp_valid1), 32'd0);
    checkOutput("reset rdata", rsp_rdata1, 32'h0);
    checkOutput("reset err", 32'(rsp_err1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("reset req_ready", 32'(ready1), 32'd1);

    foreach (vecs[i]) applyStimulus(vecs[i]);

    // LATENCY=4 with req_valid held: WAIT x3, RESP, one IDLE cycle, re-accept.
    @(negedge clk);
    driveReq(1'b0, 2'b10, 1'b0, 32'h010, 32'h0);
    valid4 = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("lat4 ready c%0d", k + 1), 32'(ready4), 32'd0);
      checkOutput($sformatf("lat4 rsp_valid c%0d", k + 1), 32'(rsp_valid4), (k == 3) ? 32'd1 : 32'd0);
      @(posedge clk);
    end
    #1;
    checkOutput("lat4 rdata", rsp_rdata4, 32'h0000_0004);
    checkOutput("lat4 idle ready", 32'(ready4), 32'd1);
    checkOutput("lat4 idle rsp_valid", 32'(rsp_valid4), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat4 re-accept", 32'(ready4), 32'd0);
    valid4 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("lat4 drain idle", 32'(ready4), 32'd1);

    // LATENCY=3: reset during WAIT drops the store and its response.
    @(negedge clk);
    driveReq(1'b1, 2'b10, 1'b0, 32'h030, 32'hDEAD_BEEF);
    valid3 = 1'b1;
    @(posedge clk);
    #1;
    valid3 = 1'b0;
    checkOutput("lat3 accepted", 32'(ready3), 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("lat3 reset ready", 32'(ready3), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      checkOutput("lat3 no rsp in reset", 32'(rsp_valid3), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("lat3 no rsp after reset", 32'(rsp_valid3), 32'd0);
    end
    runLat3("lat3 ld 0x30 dropped", 1'b0, 32'h030, 32'h0, 32'h0000_000C);
    runLat3("lat3 st 0x30", 1'b1, 32'h030, 32'hDEAD_BEEF, 32'h0);
    runLat3("lat3 ld 0x30 stored", 1'b0, 32'h030, 32'h0, 32'hDEAD_BEEF);

    // Array contents survive reset.
    applyStimulus('{"ld w 0x20 post reset", 1'b0, 2'b10, 1'b0, 32'h020, 32'h0, 32'h0000_AB08, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
